// File: rtl/image_bouncer.sv
// Screen-saver position stage: bounces an IMG_W x IMG_H window around the
// active area and converts screen coordinates into image-local coordinates,
// with an enable flag delayed to match the downstream image block latency.
module image_bouncer #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int IMG_W     = 16,
    parameter int IMG_H     = 256,
    parameter int STEP      = 1,
    parameter int SPEED_DIV = 1,
    parameter int PIPE_DLY  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x_px,
    input  logic [9:0] y_px,
    input  logic       activevideo,
    input  logic       frame_tick,
    input  logic       enable,
    output logic [7:0] x_img,
    output logic [7:0] y_img,
    output logic       hit,
    output logic       img_en,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y
);

    localparam int MAX_X = H_ACTIVE - IMG_W;
    localparam int MAX_Y = V_ACTIVE - IMG_H;

    logic [9:0]          pos_x_q, pos_x_d;
    logic [9:0]          pos_y_q, pos_y_d;
    // Direction flags: 1 = moving towards larger coordinates.
    logic                dir_x_q, dir_x_d;
    logic                dir_y_q, dir_y_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                hit_q, hit_d;
    logic [7:0]          x_img_q, x_img_d;
    logic [7:0]          y_img_q, y_img_d;
    logic [PIPE_DLY-1:0] en_pipe_q, en_pipe_d;

    logic [10:0] x_ext, y_ext, px_ext, py_ext, dx, dy;
    logic        in_x, in_y;

    // Window test against the current (pre-move) position, 11-bit so the
    // upper bound never wraps.
    always_comb begin
        x_ext   = {1'b0, x_px};
        y_ext   = {1'b0, y_px};
        px_ext  = {1'b0, pos_x_q};
        py_ext  = {1'b0, pos_y_q};
        in_x    = (x_ext >= px_ext) && (x_ext < px_ext + 11'(IMG_W));
        in_y    = (y_ext >= py_ext) && (y_ext < py_ext + 11'(IMG_H));
        hit_d   = in_x & in_y & activevideo;
        dx      = x_ext - px_ext;
        dy      = y_ext - py_ext;
        x_img_d = hit_d ? dx[7:0] : 8'd0;
        y_img_d = hit_d ? dy[7:0] : 8'd0;
    end

    // Frame divider and per-axis bounce; position only moves on a frame_tick.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        cnt_d   = cnt_q;
        if (frame_tick) begin
            if (cnt_q == 8'(SPEED_DIV - 1)) begin
                cnt_d = 8'd0;
                if (enable) begin
                    if (dir_x_q) begin
                        if ({1'b0, pos_x_q} + 11'(STEP) >= 11'(MAX_X)) begin
                            pos_x_d = 10'(MAX_X);
                            dir_x_d = 1'b0;
                        end else begin
                            pos_x_d = pos_x_q + 10'(STEP);
                        end
                    end else if (pos_x_q <= 10'(STEP)) begin
                        pos_x_d = 10'd0;
                        dir_x_d = 1'b1;
                    end else begin
                        pos_x_d = pos_x_q - 10'(STEP);
                    end
                    if (dir_y_q) begin
                        if ({1'b0, pos_y_q} + 11'(STEP) >= 11'(MAX_Y)) begin
                            pos_y_d = 10'(MAX_Y);
                            dir_y_d = 1'b0;
                        end else begin
                            pos_y_d = pos_y_q + 10'(STEP);
                        end
                    end else if (pos_y_q <= 10'(STEP)) begin
                        pos_y_d = 10'd0;
                        dir_y_d = 1'b1;
                    end else begin
                        pos_y_d = pos_y_q - 10'(STEP);
                    end
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Delay chain that lines hit up with the image block's pixel output.
    always_comb begin
        en_pipe_d    = en_pipe_q;
        en_pipe_d[0] = hit_q;
        for (int i = 1; i < PIPE_DLY; i++) begin
            en_pipe_d[i] = en_pipe_q[i-1];
        end
    end

    // State and output registers; reset clears everything including the chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x_q   <= 10'd0;
            pos_y_q   <= 10'd0;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            cnt_q     <= 8'd0;
            hit_q     <= 1'b0;
            x_img_q   <= 8'd0;
            y_img_q   <= 8'd0;
            en_pipe_q <= '0;
        end else begin
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            x_img_q   <= x_img_d;
            y_img_q   <= y_img_d;
            en_pipe_q <= en_pipe_d;
        end
    end

    assign x_img  = x_img_q;
    assign y_img  = y_img_q;
    assign hit    = hit_q;
    assign img_en = en_pipe_q[PIPE_DLY-1];
    assign pos_x  = pos_x_q;
    assign pos_y  = pos_y_q;

endmodule
